// File: rtl/uart_pkg.sv
// Shared definitions for the N-byte UART link (transmitter and receiver).
// Framing: 2 clocks per bit, 8 data bits MSB first, one-cycle wake-up low per frame.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWake  = 3'd1,
        StStart = 3'd2,
        StData  = 3'd3,
        StStop  = 3'd4
    } uart_state_e;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned CLKS_PER_BIT       = 2;
    localparam int unsigned BYTE_CNT_W_DEFAULT = 10;

endpackage

// File: rtl/uart_tx_hold_buf.sv
// One-entry holding register between the byte stream and the transmit shifter.
// Accepts a byte when the owner enables acceptance and the entry is empty.
module uart_tx_hold_buf
    import uart_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 accept_en_i,
    input  logic                 in_valid_i,
    input  logic [DATA_BITS-1:0] in_data_i,
    output logic                 in_ready_o,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic [DATA_BITS-1:0] data_o
);

    logic                 full_q, full_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 push;

    assign in_ready_o = accept_en_i && !full_q;
    assign push       = in_valid_i && in_ready_o;
    assign full_o     = full_q;
    assign data_o     = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) begin
            full_d = 1'b0;
        end
        if (push) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/uart_tx_nbyte.sv
// N-byte UART transmitter: one wake-up low, then start/8 data/stop per byte, back to back.
// Later bytes arrive through a one-entry holding buffer while the current byte shifts out.
module uart_tx_nbyte
    import uart_pkg::*;
#(
    parameter int unsigned BYTE_CNT_W = BYTE_CNT_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tx_start,
    input  logic [BYTE_CNT_W-1:0] bytes_to_tx,
    input  logic [7:0]            tx_data_byte,
    input  logic                  tx_data_valid,
    output logic                  tx_data_ready,
    output logic                  serial_data_out,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_underrun
);

    uart_state_e             state_q, state_d;
    logic                    phase_q, phase_d;
    logic [2:0]              bit_q, bit_d;
    logic [BYTE_CNT_W-1:0]   acc_q, acc_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d;
    logic                    line_q, line_d;
    logic                    done_q, done_d;
    logic                    under_q, under_d;

    logic                    phase_last;
    logic                    accept_en;
    logic                    accept;
    logic                    buf_full;
    logic                    buf_pop;
    logic [DATA_BITS-1:0]    buf_data;

    assign phase_last      = (phase_q == 1'(CLKS_PER_BIT - 1));
    assign accept          = tx_data_valid && tx_data_ready;
    assign serial_data_out = line_q;
    assign tx_done         = done_q;
    assign tx_underrun     = under_q;

    uart_tx_hold_buf u_hold_buf (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .accept_en_i (accept_en),
        .in_valid_i  (tx_data_valid),
        .in_data_i   (tx_data_byte),
        .in_ready_o  (tx_data_ready),
        .pop_i       (buf_pop),
        .full_o      (buf_full),
        .data_o      (buf_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        buf_pop = 1'b0;
        done_d  = 1'b0;
        under_d = 1'b0;
        if (accept) begin
            acc_d = acc_q - BYTE_CNT_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                phase_d = 1'b0;
                bit_d   = 3'd0;
                // The first byte rides in with tx_start; it never passes through the buffer.
                if (tx_start && tx_data_valid) begin
                    shift_d = tx_data_byte;
                    acc_d   = bytes_to_tx;
                    state_d = StWake;
                end
            end
            StWake: begin
                phase_d = 1'b0;
                state_d = StStart;
            end
            StStart: begin
                phase_d = ~phase_q;
                if (phase_last) begin
                    bit_d   = 3'(DATA_BITS - 1);
                    state_d = StData;
                end
            end
            StData: begin
                phase_d = ~phase_q;
                if (phase_last) begin
                    if (bit_q == 3'd0) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            StStop: begin
                phase_d = ~phase_q;
                if (phase_last) begin
                    if (buf_full) begin
                        buf_pop = 1'b1;
                        shift_d = buf_data;
                        state_d = StStart;
                    end else if (acc_q == '0) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        under_d = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_busy   = (state_q != StIdle);
        // No hand-over in the last stop cycle: the byte would arrive after the pop decision.
        accept_en = tx_busy && (acc_q != '0) && !((state_q == StStop) && phase_last);
    end

    always_comb begin
        line_d = 1'b1;
        unique case (state_d)
            StIdle:  line_d = 1'b1;
            StWake:  line_d = 1'b0;
            StStart: line_d = 1'b0;
            StData:  line_d = shift_d[bit_d];
            StStop:  line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            bit_q   <= 3'd0;
            acc_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            done_q  <= done_d;
            under_q <= under_d;
        end
    end

endmodule

// File: doc/uart_tx_nbyte.md
# uart_tx_nbyte

N-byte UART transmitter: the peer of the N-byte receiver on the same serial link, using the same 2-clocks-per-bit framing. It accepts a byte count (N-1) and a stream of bytes over a valid/ready handshake, then emits one continuous frame. The frame is a one-cycle wake-up low, then per byte a start bit, 8 data bits MSB first, and a stop bit. It is clocked from the baud generator output and sits between the driving device and the serial line.

## Interface
- `BYTE_CNT_W`, default 10: width of the byte-count input; N ranges from 1 to 2^BYTE_CNT_W.
- `clock`  in  1  baud-rate clock from the baud generator; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `tx_start`  in  1  request to begin a frame; sampled only in IDLE.
- `bytes_to_tx`  in  BYTE_CNT_W  number of bytes minus 1; latched at frame start.
- `tx_data_byte`  in  8  byte offered by the driving device.
- `tx_data_valid`  in  1  `tx_data_byte` is valid.
- `tx_data_ready`  out  1  transmitter accepts `tx_data_byte` this cycle (transfer occurs when valid && ready).
- `serial_data_out`  out  1  registered serial line; idles high.
- `tx_busy`  out  1  frame in progress.
- `tx_done`  out  1  one-cycle pulse when the frame completes normally.
- `tx_underrun`  out  1  one-cycle pulse when the frame is aborted for lack of data.

## Operation
- **States:** IDLE, WAKE, START, DATA, STOP.
- **Counters and registers:**
  - 1-bit phase counter (2 cycles per bit).
  - 3-bit bit counter, counting 7 down to 0.
  - BYTE_CNT_W-bit `acc_left`: bytes still to be accepted.
  - 8-bit shift register.
  - 1-entry holding buffer with a full flag.
- **IDLE:**
  - `serial_data_out`=1, `tx_busy`=0.
  - On `tx_start` && `tx_data_valid`: load the shift register with `tx_data_byte`, set `acc_left` to `bytes_to_tx`, then go to WAKE.
  - The first byte is consumed via `tx_start`. `tx_data_ready` stays 0 in IDLE.
  - `tx_start` without `tx_data_valid` is ignored.
- **WAKE:** line 0 for 1 cycle, then START.
- **START:** line 0 for 2 cycles, then DATA with bit counter at 7.
- **DATA:**
  - The line carries `shift[bit_ctr]` for 2 cycles per bit.
  - After bit 0 completes, go to STOP.
- **STOP:** line 1 for 2 cycles. At the end of the second cycle:
  - If the buffer is full: move it to the shift register, clear full, go to START (no WAKE between bytes).
  - Else if `acc_left`==0: pulse `tx_done`, go to IDLE.
  - Else: pulse `tx_underrun`, go to IDLE. The line stays high, and the receiver drops to idle at its start-bit check.
- **Handshake:**
  - `tx_data_ready` = `tx_busy` && !full && `acc_left`!=0 && !(STOP && phase==1).
  - On accept: full←1 and `acc_left`←`acc_left`-1.
  - A byte may be accepted any time during the previous byte's transmission.
- **Ignored inputs:**
  - `tx_start` while busy is ignored.
  - `bytes_to_tx` changes after the start cycle are ignored.
- **Arithmetic:** all counters are unsigned. `acc_left` never decrements below 0, because ready is gated.
- **Reset:**
  - `reset_n`=0 at any clock edge (including mid-frame) gives, next cycle: state IDLE, `serial_data_out`=1, `tx_busy`=0, `tx_data_ready`=0, `tx_done`=0, `tx_underrun`=0, full=0, counters 0.
  - The buffered byte is discarded.

## Timing
- `tx_start` is sampled at edge of cycle 0.
- **Line timeline for the first byte:**
  - Wake low in cycle 1.
  - Start low in cycles 2–3.
  - Bit 7 in cycles 4–5, down to bit 0 in cycles 18–19.
  - Stop high in cycles 20–21.
- **Subsequent bytes:** 20 cycles each (start, 8 data bits, stop), back-to-back.
- **Frame length:** `tx_busy` is high for 1+20N cycles, cycles 1 through 20N+1.
- `tx_done` / `tx_underrun` pulse in the first cycle `tx_busy` is low.
- The earliest next `tx_start` is sampled in that same cycle.
- **Receiver alignment:** the receiver samples each bit on its second cycle. Both cycles of every bit must hold the same value.
- **Buffer refill:** the last cycle to hand over byte k+1 is the first stop cycle of byte k. A byte offered only in the second stop cycle is not accepted, and the frame underruns.

## Structure
- **Shared package `uart_pkg`:**
  - state encoding localparams (IDLE/WAKE/START/DATA/STOP, 3-bit);
  - `DATA_BITS`=8;
  - `CLKS_PER_BIT`=2;
  - default `BYTE_CNT_W`=10.
- The receiver should migrate to the same package.
- **Sub-module `uart_tx_hold_buf`:** 1-entry valid/ready skid register providing `full`, `data`, and `pop`. The FSM, shifter and counters stay in the top module.

## Test plan
- **Single byte:** `bytes_to_tx`=0, byte 0xA5, `tx_start` → line 0 (1 cycle), 0 0, then 11 00 11 00 00 11 00 11, then 11. `tx_busy` high 21 cycles, `tx_done` pulse, never ready.
- **Three bytes 0x01, 0x80, 0xFF:** supplied promptly → 61-cycle frame, no WAKE between bytes, `tx_done` once. The real N-byte receiver in loopback reports the same 3 bytes with `rx_data_valid`.
- **Late byte:** `bytes_to_tx`=1, second byte withheld past the first stop → `tx_underrun` at cycle 22, line high, the receiver returns to idle. The same byte offered in the first stop cycle → normal 41-cycle frame.
- **Ignored inputs:**
  - `tx_start` with `tx_data_valid`=0 → nothing happens.
  - `tx_start` mid-frame → ignored.
  - `bytes_to_tx` changed mid-frame → frame length unchanged.
- **Reset mid-frame:** `reset_n` low during DATA bit 3 → next cycle line 1 and all outputs 0. A new frame afterwards transmits correctly.
- **Maximum count:** `bytes_to_tx`=1023 with a streaming counter pattern → 1024 bytes, `tx_busy` high for 20481 cycles, exactly 1023 accepts.
